// File: rtl/twi_mirror_arbiter_pkg.sv
// Shared TWI definitions: arbiter state encoding, START/STOP event bit
// positions, the state-to-output decode and a small constant helper.
package twi_mirror_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOST   = 2'd1,
    ST_LOCAL  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  // Bit positions of START/STOP in event vectors used by other TWI blocks.
  localparam int unsigned EV_START = 0;
  localparam int unsigned EV_STOP  = 1;

  typedef struct packed {
    logic localGnt;
    logic selLocal;
    logic proxyEnable;
    logic busBusy;
  } out_t;

  function automatic out_t decode_outputs(state_e st);
    out_t o;
    o.localGnt    = (st == ST_LOCAL);
    o.selLocal    = (st == ST_LOCAL);
    o.proxyEnable = (st != ST_LOCAL);
    o.busBusy     = (st != ST_IDLE);
    return o;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/twi_mirror_arbiter_if.sv
// Mirror-bus arbitration bundle.
//   hostScl/hostSdaIn : raw host pins
//   localReq/localDone: local master request level / release pulse
//   localGnt, selLocal, proxyEnable, busBusy: registered ownership status
//   hostCollision, localTimeout: 1-cycle event pulses
// master = pin/request driver side, slave = arbiter side.
interface twi_mirror_arbiter_if;
  logic hostScl;
  logic hostSdaIn;
  logic localReq;
  logic localDone;
  logic localGnt;
  logic selLocal;
  logic proxyEnable;
  logic busBusy;
  logic hostCollision;
  logic localTimeout;

  modport master (
    output hostScl, hostSdaIn, localReq, localDone,
    input  localGnt, selLocal, proxyEnable, busBusy, hostCollision, localTimeout
  );

  modport slave (
    input  hostScl, hostSdaIn, localReq, localDone,
    output localGnt, selLocal, proxyEnable, busBusy, hostCollision, localTimeout
  );
endinterface

// File: rtl/twi_mirror_arbiter_bus_monitor.sv
// twi_bus_monitor: synchronizes raw host SCL/SDA and flags START/STOP.
//   clk, rst            : clock, async active-high reset (flops reset to 1)
//   hostScl, hostSdaIn  : raw pins
//   sclSync, sdaSync    : synchronized pin levels
//   startDet, stopDet   : combinational, valid for one cycle per event
module twi_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hostScl,
  input  logic hostSdaIn,
  output logic sclSync,
  output logic sdaSync,
  output logic startDet,
  output logic stopDet
);
  logic [SYNC_STAGES-1:0] sclSh_q, sdaSh_q;
  logic                   sclPrev_q, sdaPrev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclSh_q   <= '1;
      sdaSh_q   <= '1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSh_q   <= {sclSh_q[SYNC_STAGES-2:0], hostScl};
      sdaSh_q   <= {sdaSh_q[SYNC_STAGES-2:0], hostSdaIn};
      sclPrev_q <= sclSh_q[SYNC_STAGES-1];
      sdaPrev_q <= sdaSh_q[SYNC_STAGES-1];
    end
  end

  assign sclSync = sclSh_q[SYNC_STAGES-1];
  assign sdaSync = sdaSh_q[SYNC_STAGES-1];

  // SCL must be high on both samples around the SDA edge.
  assign startDet = sclPrev_q & sclSync &  sdaPrev_q & ~sdaSync;
  assign stopDet  = sclPrev_q & sclSync & ~sdaPrev_q &  sdaSync;
endmodule

// File: rtl/twi_mirror_arbiter.sv
// twi_mirror_arbiter: shares the mirrored I2C bus between the host (through
// the pass-through proxy) and the local master.
//   clk, rst : clock, async active-high reset (resets into SETTLE)
//   bus      : twi_mirror_arbiter_if.slave (pins, request/release, status)
// TIMEOUT_CYCLES = 0 disables the local ownership timeout.
module twi_mirror_arbiter
  import twi_mirror_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned IDLE_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic            clk,
  input logic            rst,
  twi_mirror_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(max_u(IDLE_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic sclSync, sdaSync, startDet, stopDet;

  twi_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk      (clk),
    .rst      (rst),
    .hostScl  (bus.hostScl),
    .hostSdaIn(bus.hostSdaIn),
    .sclSync  (sclSync),
    .sdaSync  (sdaSync),
    .startDet (startDet),
    .stopDet  (stopDet)
  );

  state_e          state_q, state_d;
  logic [CW-1:0]   settleCnt_q, settleCnt_d;
  logic [CW-1:0]   toCnt_q, toCnt_d;
  logic            collision_d, timeout_d;
  logic            collision_q, timeout_q;
  out_t            out_q;

  function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    toCnt_d     = toCnt_q;
    collision_d = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Host wins a same-cycle START vs request.
        if (startDet)          state_d = ST_HOST;
        else if (bus.localReq) state_d = ST_LOCAL;
      end
      ST_HOST: begin
        if (stopDet) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (startDet)                    state_d     = ST_HOST;
        else if (!(sclSync && sdaSync))  settleCnt_d = '0;
        else if (settleCnt_q == SETTLE_LAST) state_d = ST_IDLE;
        else                             settleCnt_d = sat_inc(settleCnt_q);
      end
      ST_LOCAL: begin
        collision_d = startDet;
        if (bus.localDone) begin
          state_d = ST_SETTLE;
        end else if (TIMEOUT_CYCLES != 0 && toCnt_q == TIMEOUT_LAST) begin
          state_d   = ST_SETTLE;
          timeout_d = 1'b1;
        end else begin
          toCnt_d = sat_inc(toCnt_q);
        end
      end
      default: state_d = ST_SETTLE;
    endcase
    if (state_d != state_q) begin
      settleCnt_d = '0;
      toCnt_d     = '0;
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      settleCnt_q <= '0;
      toCnt_q     <= '0;
      out_q       <= decode_outputs(ST_SETTLE);
      collision_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      toCnt_q     <= toCnt_d;
      out_q       <= decode_outputs(state_d);
      collision_q <= collision_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.localGnt      = out_q.localGnt;
  assign bus.selLocal      = out_q.selLocal;
  assign bus.proxyEnable   = out_q.proxyEnable;
  assign bus.busBusy       = out_q.busBusy;
  assign bus.hostCollision = collision_q;
  assign bus.localTimeout  = timeout_q;
endmodule
